// File: rtl/inst_buffer_if.sv
// Fetch-to-decode stream bundle for inst_buffer: producer side, consumer side,
// redirect flush and occupancy. The slave modport is the buffer's view.
interface inst_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PC_W  = 32;

  logic                  valid_i;
  logic                  ready_o;
  logic [PC_W-1:0]       pc_i;
  logic [DATA_WIDTH-1:0] inst_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [PC_W-1:0]       pc_o;
  logic [DATA_WIDTH-1:0] inst_o;
  logic                  flush_i;
  logic [PTR_W:0]        count_o;

  modport master (
    output valid_i, pc_i, inst_i, ready_i, flush_i,
    input  ready_o, valid_o, pc_o, inst_o, count_o
  );

  modport slave (
    input  valid_i, pc_i, inst_i, ready_i, flush_i,
    output ready_o, valid_o, pc_o, inst_o, count_o
  );
endinterface

// File: rtl/inst_buffer.sv
// Instruction buffer: circular FIFO of {pc, inst} between Fetch and decode.
// ready_o is a function of registered pointers only, so decode stalls never reach Fetch combinationally.
module inst_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input logic          clk,
  input logic          reset,
  inst_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PC_W  = 32;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           empty_c, full_c, push_c, pop_c;

  // Pointer MSB is a wrap bit: equal low bits with differing MSBs means full.
  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
               (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    push_c   = bus.valid_i && !full_c && !bus.flush_i;
    pop_c    = bus.ready_i && !empty_c && !bus.flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[PTR_W-1:0]] <= '{pc: bus.pc_i, inst: bus.inst_i};
  end

  assign bus.ready_o = !full_c;
  assign bus.valid_o = !empty_c;
  assign bus.pc_o    = mem_q[rd_ptr_q[PTR_W-1:0]].pc;
  assign bus.inst_o  = mem_q[rd_ptr_q[PTR_W-1:0]].inst;
  assign bus.count_o = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: a queue-based reference model checked every cycle,
// a directed vector table, hand-written fill/drain/stream sequences and random traffic.
module tb_inst_buffer;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  typedef struct packed {
    logic [31:0]   pc;
    logic [DW-1:0] inst;
  } ent_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        r;
    logic        f;
    int          e_cnt;
    logic        e_val;
    logic        e_rdy;
    logic [31:0] e_pc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
  inst_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  vec_t tbl[11];

  function automatic logic [DW-1:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic r, input logic f,
                              input int e_cnt, input logic e_val, input logic e_rdy,
                              input logic [31:0] e_pc);
    vec_t t;
    t.v = v; t.pc = pc; t.r = r; t.f = f;
    t.e_cnt = e_cnt; t.e_val = e_val; t.e_rdy = e_rdy; t.e_pc = e_pc;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output with what the queue model says it should be.
  task automatic check_model();
    check("valid_o", 64'(bus.valid_o), 64'(q.size() != 0));
    check("ready_o", 64'(bus.ready_o), 64'(q.size() != DEPTH));
    check("count_o", 64'(bus.count_o), 64'(q.size()));
    if (q.size() != 0) begin
      check("pc_o", 64'(bus.pc_o), 64'(q[0].pc));
      check("inst_o", 64'(bus.inst_o), 64'(q[0].inst));
    end
  endtask

  // Drive one cycle's inputs at the falling edge, advance the model at the rising edge, check.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [DW-1:0] inst,
                       input logic r, input logic f);
    bit do_push, do_pop;
    bus.valid_i = v;
    bus.pc_i    = pc;
    bus.inst_i  = inst;
    bus.ready_i = r;
    bus.flush_i = f;
    do_push = v && (q.size() < DEPTH) && !f;
    do_pop  = r && (q.size() != 0) && !f;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (do_pop) q.delete(0);
      if (do_push) q.push_back('{pc: pc, inst: inst});
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [31:0] seen[$];
    logic [31:0] stall_pc;
    int          sent, stall_left;
    logic        hv, hr, hf;
    logic [31:0] hpc;
    bit          hold;
    logic [31:0] next_pc;

    reset = 1'b1;
    bus.valid_i = 1'b0; bus.pc_i = '0; bus.inst_i = '0; bus.ready_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    check("rst_valid_o", 64'(bus.valid_o), 64'd0);
    check("rst_ready_o", 64'(bus.ready_o), 64'd1);
    check("rst_count_o", 64'(bus.count_o), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Partial fill, then an asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h80 + 32'(4*i), inst_of(32'h80 + 32'(4*i)), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    q.delete();
    check("midrst_valid_o", 64'(bus.valid_o), 64'd0);
    check("midrst_ready_o", 64'(bus.ready_o), 64'd1);
    check("midrst_count_o", 64'(bus.count_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors: inputs for one cycle, outputs expected after that edge.
    tbl[0]  = mk(1'b1, 32'h00,  1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h00);
    tbl[1]  = mk(1'b1, 32'h04,  1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h00);
    tbl[2]  = mk(1'b1, 32'h08,  1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h00);
    tbl[3]  = mk(1'b1, 32'h0C,  1'b1, 1'b0, 3, 1'b1, 1'b1, 32'h04);
    tbl[4]  = mk(1'b0, 32'h00,  1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h08);
    tbl[5]  = mk(1'b1, 32'h10,  1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h08);
    tbl[6]  = mk(1'b1, 32'h14,  1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h08);
    tbl[7]  = mk(1'b1, 32'h18,  1'b0, 1'b0, 5, 1'b1, 1'b1, 32'h08);
    tbl[8]  = mk(1'b1, 32'h1C,  1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h00);
    tbl[9]  = mk(1'b1, 32'h400, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h400);
    tbl[10] = mk(1'b0, 32'h00,  1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h00);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].pc, inst_of(tbl[i].pc), tbl[i].r, tbl[i].f);
      check($sformatf("vec%0d_count", i), 64'(bus.count_o), 64'(tbl[i].e_cnt));
      check($sformatf("vec%0d_valid", i), 64'(bus.valid_o), 64'(tbl[i].e_val));
      check($sformatf("vec%0d_ready", i), 64'(bus.ready_o), 64'(tbl[i].e_rdy));
      if (tbl[i].e_val) check($sformatf("vec%0d_pc", i), 64'(bus.pc_o), 64'(tbl[i].e_pc));
    end

    // Fill to full with decode stalled; a ninth pair must be held off.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(4*i), inst_of(32'(4*i)), 1'b0, 1'b0);
    check("full_count", 64'(bus.count_o), 64'd8);
    check("full_ready", 64'(bus.ready_o), 64'd0);
    repeat (2) cycle(1'b1, 32'h20, inst_of(32'h20), 1'b0, 1'b0);
    check("full_hold_count", 64'(bus.count_o), 64'd8);
    bus.ready_i = 1'b1;
    #1;
    check("no_ready_path", 64'(bus.ready_o), 64'd0);
    cycle(1'b1, 32'h20, inst_of(32'h20), 1'b1, 1'b0);
    check("full_pop_count", 64'(bus.count_o), 64'd7);
    check("full_pop_ready", 64'(bus.ready_o), 64'd1);
    for (int k = 1; k < 8; k++) begin
      check($sformatf("drain_pc%0d", k), 64'(bus.pc_o), 64'(4*k));
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check("drain_valid", 64'(bus.valid_o), 64'd0);
    check("drain_count", 64'(bus.count_o), 64'd0);

    // Streaming 40 entries with a 3-cycle decode stall at entry 10.
    sent = 0; stall_left = 3; stall_pc = '0;
    for (int c = 0; c < 400 && seen.size() < 40; c++) begin
      logic r;
      bit   acc;
      r = 1'b1;
      if (seen.size() == 10 && stall_left > 0) begin
        r = 1'b0;
        if (stall_left == 3) stall_pc = bus.pc_o;
        else check("stall_hold", 64'(bus.pc_o), 64'(stall_pc));
        stall_left--;
      end
      if (bus.valid_o && r) seen.push_back(bus.pc_o);
      acc = (sent < 40) && bus.ready_o;
      cycle(sent < 40, 32'h100 + 32'(4*sent), inst_of(32'h100 + 32'(4*sent)), r, 1'b0);
      if (acc) sent++;
    end
    check("stream_len", 64'(seen.size()), 64'd40);
    for (int i = 0; i < seen.size(); i++) begin
      if (seen[i] !== 32'h100 + 32'(4*i)) check($sformatf("stream_pc%0d", i), 64'(seen[i]), 64'(32'h100 + 32'(4*i)));
    end

    // Random traffic; the producer keeps an offered pair stable until it is taken or flushed.
    hold = 1'b0; hv = 1'b0; hpc = '0; next_pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      bit acc;
      if (!hold) begin
        hv  = ($urandom_range(0, 9) < 7);
        hpc = next_pc;
      end
      hr = ($urandom_range(0, 9) < 6);
      hf = ($urandom_range(0, 99) < 3);
      acc = hv && bus.ready_o && !hf;
      cycle(hv, hpc, inst_of(hpc) ^ 32'(c), hr, hf);
      if (acc) next_pc = next_pc + 32'd4;
      hold = hv && !acc && !hf;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Decoupling FIFO on the consumer side of the fetch stream. It accepts pc/instruction pairs from Fetch over a valid/ready handshake and presents them in order to decode on an identical valid/ready handshake. It absorbs decode stalls without creating a combinational path from decode's ready back to Fetch. A synchronous flush drops all buffered instructions when the front end is redirected.

## Interface
- DATA_WIDTH, 32, instruction width; matches the Fetch `inst_o` width
- DEPTH, 8, number of entries; power of two, minimum 2
- PTR_W, $clog2(DEPTH), derived index width; not overridden
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- valid_i  in  1  Fetch has a valid pc/inst pair
- ready_o  out  1  buffer can accept an entry this cycle
- pc_i  in  32  PC of the incoming instruction
- inst_i  in  DATA_WIDTH  incoming instruction
- valid_o  out  1  head entry valid for decode
- ready_i  in  1  decode consumes the head this cycle
- pc_o  out  32  PC of the head entry
- inst_o  out  DATA_WIDTH  instruction of the head entry
- flush_i  in  1  discard all entries (redirect)
- count_o  out  PTR_W+1  current occupancy, 0..DEPTH

## Operation
- Storage: a DEPTH-entry circular array of {pc, inst}, with write pointer wr_ptr and read pointer rd_ptr.
  - Both pointers are PTR_W+1 bits wide.
  - The low PTR_W bits index the array; the MSB is the wrap bit.
  - Pointers increment modulo 2^(PTR_W+1) and wrap naturally.
- Status flags:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - count_o = wr_ptr − rd_ptr, taken modulo 2^(PTR_W+1).
- Push: occurs when valid_i && ready_o && !flush_i.
  - Writes {pc_i, inst_i} at wr_ptr.
  - wr_ptr increments.
- Pop: occurs when valid_o && ready_i && !flush_i.
  - rd_ptr increments.
- ready_o = !full.
  - It depends only on registered state. There is no ready_i → ready_o path.
  - When the buffer is full, a simultaneous pop does not enable a push that cycle.
- valid_o = !empty. pc_o and inst_o are a combinational read of the array at rd_ptr.
- When valid_o = 0, pc_o and inst_o are don't-care. Verification does not check them.
- Simultaneous push and pop when neither empty nor full: both occur and count_o is unchanged.
- Simultaneous push and pop when empty:
  - Only the push occurs, because valid_o = 0.
  - There is no bypass; the entry appears at the output on the next cycle.
- Flush:
  - rd_ptr is set equal to wr_ptr, so the buffer is empty on the next cycle.
  - Flush has the highest priority. Any push or pop in the same cycle is ignored.
  - Array contents are not cleared.
- Reset mid-operation: all entries are lost immediately, as with a flush, but asynchronously.
- Stream protocol obligations (both sides):
  - The producer holds valid_i, pc_i and inst_i stable while valid_i && !ready_o. Fetch satisfies this.
  - The buffer holds valid_o, pc_o and inst_o stable while valid_o && !ready_i and no flush occurs.

## Timing
- Reset (asynchronous assert) outputs:
  - wr_ptr = rd_ptr = 0.
  - valid_o = 0, ready_o = 1, count_o = 0.
  - The array is not reset.
- Reset release: the first push is possible on the first rising edge after deassertion.
- Latency: an entry pushed at edge N is visible on valid_o/pc_o/inst_o after edge N, i.e. 1 cycle, if the buffer was empty.
- Throughput: 1 push and 1 pop per cycle sustained, at any occupancy 1..DEPTH−1.
- flush_i sampled high at edge N: valid_o = 0 and count_o = 0 after edge N; ready_o = 1.
- count_o, valid_o and ready_o all change only at clock edges or on reset assertion.

## Test plan
- Reset and fill:
  - Stimulus: assert reset mid-stream; after release, push PCs 0x0, 0x4, …, 0x1C with ready_i = 0.
  - Response: during reset valid_o = 0, ready_o = 1, count_o = 0.
  - Response: after 8 pushes count_o = 8 and ready_o = 0; a 9th pair (0x20) is held off and not written.
- Drain in order: from full, raise ready_i.
  - Response: pc_o steps 0x0, 0x4, …, 0x1C on consecutive cycles with matching inst_o.
  - Response: valid_o falls after the 8th pop; count_o = 0.
- Streaming with wrap:
  - Stimulus: continuous valid_i and ready_i for 40 entries, PCs 0x100 onward step 4; insert a 3-cycle ready_i = 0 stall at entry 10.
  - Response: output sequence is exactly 0x100..0x19C, with no loss or duplication.
  - Response: outputs are held stable during the stall; pointers wrap at least twice.
- Push/pop at boundaries:
  - Stimulus: when empty, assert valid_i and ready_i together. Response: no pop that cycle, count_o goes 0→1.
  - Stimulus: when full, assert ready_i and valid_i together. Response: pop only, count_o goes 8→7, ready_o = 1 on the next cycle.
- Flush priority:
  - Stimulus: with count_o = 5, assert flush_i together with valid_i, ready_o and ready_i.
  - Response: next cycle count_o = 0 and valid_o = 0; the incoming pair is not stored.
  - Response: the following push of PC 0x400 appears at pc_o one cycle later.
- Back-pressure against Fetch:
  - Stimulus: connect to Fetch (RESET_PC 0) and hold decode ready_i = 0.
  - Response: exactly DEPTH entries (PCs 0x0..0x1C) accepted; Fetch holds valid_o/pc_o at 0x20.
  - Response: after release, 0x20 follows 0x1C with no gap in the PC sequence.
